// File: rtl/mmio_port_bridge.sv
// Memory-mapped I/O bridge: 16-byte window with OUT/IN/STATUS/CHANGES registers.
// Optional input debouncer is built when MMIO_DEBOUNCE_EN is defined.
module mmio_port_bridge #(
   parameter logic [31:0] IO_BASE         = 32'h1001_0020,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [7:0]  PortIn,
   output logic        IOHit,
   output logic [31:0] ReadData,
   output logic [31:0] PortOut,
   output logic        InFlag
);

   typedef enum logic [1:0] {
      REG_OUT     = 2'd0,
      REG_IN      = 2'd1,
      REG_STATUS  = 2'd2,
      REG_CHANGES = 2'd3
   } reg_sel_e;

   reg_sel_e    sel;
   logic [31:0] out_reg;
   logic [7:0]  s1;
   logic [7:0]  s2;
   logic [7:0]  stable;
   logic [7:0]  stable_next;
   logic [7:0]  cnt8;
   logic        new_flag;
   logic        ovf_flag;
   logic        chg;
   logic        wrap;
   logic        wr_en;
   logic        wr_out;
   logic        wr_status;
   logic        rd_in;
   logic        unused_addr_bits;

   // Byte lane bits never affect the decode; words are the unit of access.
   assign unused_addr_bits = ^Address[1:0];

   assign sel   = reg_sel_e'(Address[3:2]);
   assign IOHit = (Address[31:4] == IO_BASE[31:4]);

   assign wr_en     = MemWrite & IOHit;
   assign wr_out    = wr_en & (sel == REG_OUT);
   assign wr_status = wr_en & (sel == REG_STATUS);
   assign rd_in     = MemRead & IOHit & (sel == REG_IN);

   always_comb begin
      ReadData = '0;
      if (IOHit) begin
         case (sel)
            REG_OUT:     ReadData = out_reg;
            REG_IN:      ReadData = {24'b0, stable};
            REG_STATUS:  ReadData = {30'b0, ovf_flag, new_flag};
            REG_CHANGES: ReadData = {24'b0, cnt8};
            default:     ReadData = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_reg <= '0;
      end else if (wr_out) begin
         out_reg <= WriteData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= PortIn;
         s2 <= s1;
      end
   end

`ifdef MMIO_DEBOUNCE_EN
   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [DW-1:0] dcnt;
   logic [DW-1:0] dcnt_next;

   // Any cycle where s2 matches stable restarts the count, so glitches are dropped.
   always_comb begin
      stable_next = stable;
      dcnt_next   = '0;
      if (s2 != stable) begin
         if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_next = s2;
         end else begin
            dcnt_next = dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt_next;
      end
   end
`else
   localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign stable_next = s2;
`endif

   assign chg  = (stable_next != stable);
   assign wrap = chg & (cnt8 == 8'hFF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         cnt8   <= '0;
      end else begin
         stable <= stable_next;
         if (chg) begin
            cnt8 <= cnt8 + 8'd1;
         end
      end
   end

   // Set events take priority over read-clear and W1C in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         new_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         if (chg) begin
            new_flag <= 1'b1;
         end else if (rd_in | (wr_status & WriteData[0])) begin
            new_flag <= 1'b0;
         end

         if (wrap) begin
            ovf_flag <= 1'b1;
         end else if (wr_status & WriteData[1]) begin
            ovf_flag <= 1'b0;
         end
      end
   end

   assign PortOut = out_reg;
   assign InFlag  = new_flag;

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Directed testbench for mmio_port_bridge; input latency follows MMIO_DEBOUNCE_EN.
module tb_mmio_port_bridge;

   localparam int unsigned D = 4;
`ifdef MMIO_DEBOUNCE_EN
   localparam int unsigned LAT = 2 + D;
`else
   localparam int unsigned LAT = 3;
`endif

   localparam logic [31:0] A_OUT = 32'h1001_0020;
   localparam logic [31:0] A_IN  = 32'h1001_0024;
   localparam logic [31:0] A_ST  = 32'h1001_0028;
   localparam logic [31:0] A_CNT = 32'h1001_002C;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  PortIn;
   logic        IOHit;
   logic [31:0] ReadData;
   logic [31:0] PortOut;
   logic        InFlag;

   int unsigned n_checks;
   int unsigned n_fail;

   mmio_port_bridge #(
      .IO_BASE        (32'h1001_0020),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Address  (Address),
      .WriteData(WriteData),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .PortIn   (PortIn),
      .IOHit    (IOHit),
      .ReadData (ReadData),
      .PortOut  (PortOut),
      .InFlag   (InFlag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Combinational read with no side effects.
   task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
      Address  = a;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      #1;
      check(tag, ReadData, exp);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      Address   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      @(negedge clk);
      MemWrite  = 1'b0;
   endtask

   task automatic load(input logic [31:0] a);
      Address  = a;
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      @(negedge clk);
      MemRead  = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      Address   = '0;
      WriteData = '0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      PortIn    = 8'h00;
      tick(2);
      check("rst_portout", PortOut, 32'h0);
      check("rst_inflag", {31'b0, InFlag}, 32'h0);
      reset = 1'b1;
      tick(1);

      // Reset state and window decode
      Address = A_OUT; MemRead = 1'b1; #1;
      check("rst_iohit", {31'b0, IOHit}, 32'h1);
      check("rst_out_rd", ReadData, 32'h0);
      MemRead = 1'b0;
      peek(32'h1001_0030, "miss_above_rd", 32'h0);
      check("miss_above_hit", {31'b0, IOHit}, 32'h0);
      peek(32'h1001_001C, "miss_below_rd", 32'h0);
      check("miss_below_hit", {31'b0, IOHit}, 32'h0);
      peek(32'h1001_002F, "cnt_top_byte", 32'h0);
      check("top_byte_hit", {31'b0, IOHit}, 32'h1);

      // OUT register writes
      store(A_OUT, 32'hDEAD_BEEF);
      check("out_write", PortOut, 32'hDEAD_BEEF);
      peek(A_OUT, "out_read", 32'hDEAD_BEEF);
      store(A_IN, 32'h5);
      peek(A_IN, "in_ro", 32'h0);
      store(32'h1001_0023, 32'h1234_5678);
      check("out_byte_offset", PortOut, 32'h1234_5678);
      store(32'h1001_0030, 32'hFFFF_FFFF);
      check("out_miss_nowrite", PortOut, 32'h1234_5678);

      // Input capture latency
      PortIn = 8'hA5;
      tick(LAT - 1);
      peek(A_IN, "in_before_lat", 32'h0);
      tick(1);
      peek(A_IN, "in_at_lat", 32'hA5);
      peek(A_ST, "status_new", 32'h1);
      peek(A_CNT, "changes_1", 32'h1);
      check("inflag_set", {31'b0, InFlag}, 32'h1);

`ifdef MMIO_DEBOUNCE_EN
      PortIn = 8'h5A;
      tick(1);
      PortIn = 8'hA5;
      tick(2 * LAT);
      peek(A_IN, "glitch_in", 32'hA5);
      peek(A_CNT, "glitch_changes", 32'h1);
      peek(A_ST, "glitch_status", 32'h1);
`endif

      // Read-clear of NEW and set-beats-clear races
      load(A_IN);
      peek(A_ST, "rdclr_status", 32'h0);
      PortIn = 8'h3C;
      tick(LAT - 1);
      load(A_IN);
      peek(A_ST, "race_rd_new", 32'h1);
      peek(A_IN, "race_rd_in", 32'h3C);
      load(A_IN);
      peek(A_ST, "rdclr2_status", 32'h0);
      check("inflag_clr", {31'b0, InFlag}, 32'h0);
      PortIn = 8'h11;
      tick(LAT - 1);
      store(A_ST, 32'h1);
      peek(A_ST, "race_w1c_new", 32'h1);
      store(A_ST, 32'h1);
      peek(A_ST, "w1c_new", 32'h0);
      peek(A_CNT, "changes_3", 32'h3);

      // Counter wrap and OVF
      for (int unsigned i = 0; i < 252; i++) begin
         PortIn = PortIn ^ 8'hFF;
         tick(LAT);
      end
      peek(A_CNT, "changes_255", 32'hFF);
      peek(A_ST, "pre_wrap_status", 32'h1);
      PortIn = PortIn ^ 8'hFF;
      tick(LAT - 1);
      store(A_ST, 32'h2);
      peek(A_CNT, "changes_wrap", 32'h0);
      peek(A_ST, "wrap_status", 32'h3);
      store(A_ST, 32'h3);
      peek(A_ST, "w1c_both", 32'h0);

      // Async reset in the middle of a pending change
      PortIn = 8'h77;
      tick(3);
      #2;
      reset = 1'b0;
      #1;
      check("arst_portout", PortOut, 32'h0);
      check("arst_inflag", {31'b0, InFlag}, 32'h0);
      peek(A_IN, "arst_in", 32'h0);
      peek(A_CNT, "arst_changes", 32'h0);
      peek(A_ST, "arst_status", 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick(LAT - 1);
      peek(A_IN, "post_rst_before", 32'h0);
      tick(1);
      peek(A_IN, "post_rst_in", 32'h77);
      peek(A_CNT, "post_rst_changes", 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mmio_port_bridge.md
Name: mmio_port_bridge

Overview:
Memory-mapped I/O bridge on the processor's data-memory bus, sitting beside the data RAM, downstream of the ALU address/store-data path and upstream of the write-back mux. Decodes a 16-byte I/O window: drives the 32-bit PortOut register and samples the 8-bit PortIn through a synchronizer and optional debouncer. Exposes a change flag and a change counter so polled programs detect new input. IOHit tells the top level to take ReadData from this block and suppress the RAM write.

Parameters:
IO_BASE, 32'h1001_0020, byte base of the I/O window; must be 16-byte aligned
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before an input change is accepted (>=1; used only with debounce)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Address  input  32  byte address from ALU result
WriteData  input  32  store data (Rt)
MemWrite  input  1  store strobe from control
MemRead  input  1  load strobe from control
PortIn  input  8  asynchronous external input pins
IOHit  output  1  Address inside the I/O window (combinational)
ReadData  output  32  load data for write-back (combinational)
PortOut  output  32  output register contents
InFlag  output  1  copy of STATUS bit0, for an LED or future interrupt

Behaviour:
- Reset (reset=0, async): OUT=0, sync stages=0, stable input=0, debounce count=0, STATUS=0, CHANGES=0. PortOut=0, InFlag=0.
- Decode: IOHit = (Address[31:4] == IO_BASE[31:4]). Register select = Address[3:2]; Address[1:0] ignored.
- Map: 0 OUT (R/W), 1 IN (RO, {24'b0, stable}), 2 STATUS (bit0 NEW, bit1 OVF, others read 0; W1C), 3 CHANGES (RO, {24'b0, cnt8}).
- ReadData: selected register when IOHit, else 0. Pure combinational, same cycle as the address (single-cycle core).
- Writes at rising clk when MemWrite & IOHit. OUT takes the full WriteData. STATUS: each of bits [1:0] written 1 clears. Writes to IN/CHANGES are ignored.
- Synchronizer: two flops, PortIn -> s1 -> s2.
- Input acceptance (stable update) raises event "chg" for one cycle:
  - stable_next != stable.
  - On chg: NEW<=1; cnt8<=cnt8+1, wrapping 255->0.
  - Wrap 255->0 sets OVF (sticky).
- Read clear: MemRead & IOHit & select==1 clears NEW at the clock edge.
- Simultaneous events: set beats clear.
  - chg in the same cycle as the IN-read clear or the STATUS W1C: NEW ends 1.
  - Wrap in the same cycle as an OVF W1C: OVF ends 1.
- MemRead and MemWrite both high on the same word: write applies, read side effect also applies.
- Async reset mid-operation discards any pending debounce. No other abort path.

Optional Feature:
Macro MMIO_DEBOUNCE_EN.
- Defined:
  - Counter dcnt. If s2 != stable: when dcnt == DEBOUNCE_CYCLES-1, stable<=s2 and dcnt<=0; otherwise dcnt<=dcnt+1.
  - If s2 == stable: dcnt<=0, so a glitch restarts the count.
  - A PortIn change held steady is visible in IN 2+DEBOUNCE_CYCLES edges after it occurs.
- Undefined: stable<=s2 every cycle, so latency is 3 edges. DEBOUNCE_CYCLES is unused and no dcnt logic is built.

Test Plan:
- Reset check: release reset, Address=0x10010020 MemRead=1 -> IOHit=1, ReadData=0, PortOut=0. Address=0x10010030 -> IOHit=0, ReadData=0.
- OUT write: store 0xDEADBEEF to 0x10010020 -> PortOut=0xDEADBEEF after that edge. Load 0x10010020 returns 0xDEADBEEF. Store 0x5 to 0x10010024 -> IN unchanged.
- Input capture (debounce on, D=4): PortIn 0x00->0xA5 held -> IN reads 0xA5 from edge 6, NEW=1, CHANGES=1. 1-cycle glitch to 0x5A -> IN, NEW and CHANGES unchanged.
- Flag race: arrange an accepted change on the same edge as a load from 0x10010024 -> NEW=1 afterwards. Next load of IN with no change -> NEW=0.
- Counter wrap: 256 accepted changes -> CHANGES=0, STATUS=0x2|NEW. Store 0x3 to 0x10010028 -> STATUS=0.
- Async reset mid-debounce: change PortIn, assert reset at edge 4 -> everything 0 immediately, without waiting for a clock edge. Release with PortIn held -> IN updates 2+D edges after release.
